// File: rtl/mux_tt_sequencer.sv
// Truth-table sequencer for a 2:1 inverting mux (y = c ? ~a : a, i.e. y = a ^ c).
// Latency: start in cycle T -> done pulse in cycle T+1+4*(SETTLE_CYCLES+1).
// Backpressure: none; start is only accepted in IDLE, requests while busy/done are dropped.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   start      - request one four-vector sweep (sampled only in IDLE)
//   a_out      - drives mux data input 'a'
//   c_out      - drives mux select input 'c'
//   y_in       - mux output 'y', sampled once per vector
//   busy       - high while driving/sampling vectors
//   done       - one-cycle pulse at the end of a sweep
//   result     - captured y per vector, result[{a,c}] = y
//   err_count  - vectors where y_in disagreed with a ^ c
//   pass       - last completed sweep had no errors
module mux_tt_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a_out,
  output logic       c_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [2:0] err_count,
  output logic       pass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Settle counter runs 0..SETTLE_CYCLES-1 so DRIVE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [3:0] cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  if (cnt == CNT_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (idx == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: vector lines are only driven while a sweep is active
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    a_out = 1'b0;
    c_out = 1'b0;
    case (state)
      S_DRIVE, S_SAMPLE: begin
        busy  = 1'b1;
        a_out = idx[1];
        c_out = idx[0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep datapath: vector index, settle counter and captured results.
  // result/err_count/pass are left untouched in IDLE so software can read
  // them at leisure until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 2'd0;
      cnt       <= 4'd0;
      result    <= 4'd0;
      err_count <= 3'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= 2'd0;
            cnt       <= 4'd0;
            result    <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (cnt != CNT_LAST) cnt <= cnt + 4'd1;
        end
        S_SAMPLE: begin
          result[idx] <= y_in;
          // At most four increments per sweep, so the 3-bit count cannot wrap.
          if (y_in != (idx[1] ^ idx[0])) err_count <= err_count + 3'd1;
          if (idx != 2'd3) begin
            idx <= idx + 2'd1;
            cnt <= 4'd0;
          end
        end
        S_DONE: begin
          pass <= (err_count == 3'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_tt_sequencer.sv
module tb_mux_tt_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       a_out;
  logic       c_out;
  logic       y_in;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [2:0] err_count;
  logic       pass;

  // 0: correct mux (y = a^c), 1: y stuck at 0, 2: inverted mux
  int mode;

  int n_checks;
  int n_fail;

  mux_tt_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_out     (a_out),
    .c_out     (c_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err_count (err_count),
    .pass      (pass)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the mux under test
  always_comb begin
    case (mode)
      1:       y_in = 1'b0;
      2:       y_in = ~(a_out ^ c_out);
      default: y_in = a_out ^ c_out;
    endcase
  end

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, done, a_out, c_out} in cycle T+k of a sweep (SETTLE_CYCLES=2).
  function automatic logic [3:0] exp_ctl(input int k);
    logic [1:0] v;
    if (k >= 1 && k <= 12) begin
      v = 2'((k - 1) / 3);
      return {1'b1, 1'b0, v[1], v[0]};
    end else if (k == 13) begin
      return 4'b0100;
    end
    return 4'b0000;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, a_out, c_out, result, err_count, pass} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b done=%b a=%b c=%b result=%b err=%0d pass=%b exp all 0",
               busy, done, a_out, c_out, result, err_count, pass);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_hold;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({busy, done, a_out, c_out, result, err_count, pass} !== 12'd0) begin
        n_fail++;
        $display("FAIL idle_hold cyc=%0d got busy=%b done=%b a=%b c=%b result=%b err=%0d pass=%b exp all 0",
                 i, busy, done, a_out, c_out, result, err_count, pass);
      end
    end
  endtask

  task automatic test_correct_sweep;
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      n_checks++;
      if ({busy, done, a_out, c_out} !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL sweep_ctl k=%0d got %b exp %b", k, {busy, done, a_out, c_out}, exp_ctl(k));
      end
      tick();
    end
    n_checks++;
    if ({done, result, err_count, pass} !== {1'b0, 4'b0110, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sweep_final got done=%b result=%b err=%0d pass=%b exp 0 0110 0 1",
               done, result, err_count, pass);
    end
    // Results must hold in IDLE regardless of what y does.
    mode = 2;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({busy, result, err_count, pass} !== {1'b0, 4'b0110, 3'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL result_hold cyc=%0d got busy=%b result=%b err=%0d pass=%b exp 0 0110 0 1",
                 i, busy, result, err_count, pass);
      end
    end
    mode = 0;
  endtask

  task automatic test_fault_models;
    logic [3:0] exp_res [2];
    logic [2:0] exp_err [2];
    exp_res[0] = 4'b0000; exp_err[0] = 3'd2;  // stuck at 0
    exp_res[1] = 4'b1001; exp_err[1] = 3'd4;  // inverted
    for (int m = 0; m < 2; m++) begin
      mode  = m + 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      // Previous sweep's results are cleared when the new one is accepted.
      n_checks++;
      if ({busy, result, err_count, pass} !== {1'b1, 4'b0000, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL fault%0d_clear got busy=%b result=%b err=%0d pass=%b exp 1 0000 0 0",
                 m, busy, result, err_count, pass);
      end
      for (int k = 1; k < 13; k++) tick();
      n_checks++;
      if ({done, err_count} !== {1'b1, exp_err[m]}) begin
        n_fail++;
        $display("FAIL fault%0d_done got done=%b err=%0d exp 1 %0d", m, done, err_count, exp_err[m]);
      end
      tick();
      n_checks++;
      if ({result, err_count, pass} !== {exp_res[m], exp_err[m], 1'b0}) begin
        n_fail++;
        $display("FAIL fault%0d_final got result=%b err=%0d pass=%b exp %b %0d 0",
                 m, result, err_count, pass, exp_res[m], exp_err[m]);
      end
    end
    mode = 0;
  endtask

  task automatic test_restart_ignored;
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      n_checks++;
      if ({busy, done, a_out, c_out} !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL restart_ctl k=%0d got %b exp %b", k, {busy, done, a_out, c_out}, exp_ctl(k));
      end
      // Re-request during vector 1 and again during DONE; both must be dropped.
      start = (k == 5 || k == 13);
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy, done, result, pass} !== {1'b0, 1'b0, 4'b0110, 1'b1}) begin
        n_fail++;
        $display("FAIL restart_after cyc=%0d got busy=%b done=%b result=%b pass=%b exp 0 0 0110 1",
                 i, busy, done, result, pass);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset;
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    n_checks++;
    if ({busy, done, a_out, c_out} !== 4'b1010) begin
      n_fail++;
      $display("FAIL midrst_pre got %b exp 1010", {busy, done, a_out, c_out});
    end
    reset = 1'b1;
    start = 1'b1;  // reset must win over start
    tick();
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({busy, done, a_out, c_out, result, err_count, pass} !== 12'd0) begin
      n_fail++;
      $display("FAIL midrst_state got busy=%b done=%b a=%b c=%b result=%b err=%0d pass=%b exp all 0",
               busy, done, a_out, c_out, result, err_count, pass);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle got busy=%b exp 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      n_checks++;
      if ({busy, done, a_out, c_out} !== exp_ctl(k)) begin
        n_fail++;
        $display("FAIL midrst_ctl k=%0d got %b exp %b", k, {busy, done, a_out, c_out}, exp_ctl(k));
      end
      tick();
    end
    n_checks++;
    if ({result, err_count, pass} !== {4'b0110, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_final got result=%b err=%0d pass=%b exp 0110 0 1", result, err_count, pass);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mode     = 0;
    reset    = 1'b1;
    start    = 1'b0;
    test_reset();
    test_idle_hold();
    test_correct_sweep();
    test_fault_models();
    test_restart_ignored();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
